// File: rtl/mssd_mpu_region_unit.sv
// Per-core MPU: region lookup with first-hit priority, R/W/X checks,
// one-cycle registered result and sticky fault capture.
//
// Ports:
//   AClkH/AResetH/AClkHEn  clock, sync active-high reset, clock enable
//   ACfgWrEn/ACfgIdx/ACfgMosi/ACfgMiso  region config write and read-back
//   AReq/AKind/AAddrCpu    lookup request (kind 00 R, 01 W, 10 X, 11 bad)
//   AAckValid/AAddrMpu/AErr/AHitIdx  registered lookup result
//   AFaultValid/AFaultAddr/AFaultKind/AFaultCnt/AFaultClr  fault capture
module mssd_mpu_region_unit #(
    parameter int CRegionCnt = 4,
    parameter int CFaultCntW = 8
) (
    input  logic                  AClkH,
    input  logic                  AResetH,
    input  logic                  AClkHEn,
    input  logic                  ACfgWrEn,
    input  logic [3:0]            ACfgIdx,
    input  logic [63:0]           ACfgMosi,
    output logic [63:0]           ACfgMiso,
    input  logic                  AReq,
    input  logic [1:0]            AKind,
    input  logic [31:0]           AAddrCpu,
    output logic                  AAckValid,
    output logic [31:0]           AAddrMpu,
    output logic                  AErr,
    output logic [3:0]            AHitIdx,
    output logic                  AFaultValid,
    output logic [31:0]           AFaultAddr,
    output logic [1:0]            AFaultKind,
    input  logic                  AFaultClr,
    output logic [CFaultCntW-1:0] AFaultCnt
);

    // Storage sized for the maximum region count; entries at or above
    // CRegionCnt are never written and stay zero.
    logic [63:0] cfgQ [16];
    logic        idxOk;

    assign idxOk    = {1'b0, ACfgIdx} < 5'(CRegionCnt);
    assign ACfgMiso = idxOk ? cfgQ[ACfgIdx] : 64'h0;

    always_ff @(posedge AClkH) begin
        for (int i = 0; i < 16; i++) begin
            if (AResetH) begin
                cfgQ[i] <= '0;
            end else if (AClkHEn && ACfgWrEn && i < CRegionCnt &&
                         ACfgIdx == 4'(i)) begin
                cfgQ[i] <= ACfgMosi;
            end
        end
    end

    // Region search. Lower index wins, so the first hit found is kept.
    logic        anyUse;
    logic        hit;
    logic [3:0]  hitIdx;
    logic [63:0] hitCfg;
    logic [19:0] fld;

    always_comb begin
        anyUse = 1'b0;
        hit    = 1'b0;
        hitIdx = '0;
        hitCfg = '0;
        fld    = '0;
        for (int i = 0; i < CRegionCnt; i++) begin
            fld = cfgQ[i][63] ? AAddrCpu[31:12] : AAddrCpu[23:4];
            if (cfgQ[i][39:20] != 20'h0) begin
                anyUse = 1'b1;
                if (!hit && fld >= cfgQ[i][19:0] &&
                    fld < cfgQ[i][39:20]) begin
                    hit    = 1'b1;
                    hitIdx = 4'(i);
                    hitCfg = cfgQ[i];
                end
            end
        end
    end

    logic [31:0] offset;
    logic        permOk;
    logic [31:0] resAddr;
    logic        resErr;
    logic [3:0]  resIdx;

    assign offset = hitCfg[63] ? {hitCfg[59:40], 12'h0}
                               : {8'h0, hitCfg[59:40], 4'h0};

    always_comb begin
        permOk = 1'b0;
        unique case (AKind)
            2'b00:   permOk = hitCfg[60];
            2'b01:   permOk = hitCfg[61];
            2'b10:   permOk = hitCfg[62];
            default: permOk = 1'b0;
        endcase
    end

    always_comb begin
        resAddr = AAddrCpu;
        resErr  = 1'b0;
        resIdx  = '0;
        if (anyUse) begin
            if (hit) begin
                resAddr = AAddrCpu + offset;
                resErr  = !permOk;
                resIdx  = hitIdx;
            end else begin
                resErr  = 1'b1;
            end
        end
    end

    logic newFault;
    assign newFault = AReq && resErr;

    always_ff @(posedge AClkH) begin
        if (AResetH) begin
            AAckValid   <= 1'b0;
            AAddrMpu    <= '0;
            AErr        <= 1'b0;
            AHitIdx     <= '0;
            AFaultValid <= 1'b0;
            AFaultAddr  <= '0;
            AFaultKind  <= '0;
            AFaultCnt   <= '0;
        end else if (AClkHEn) begin
            AAckValid <= AReq;
            if (AReq) begin
                AAddrMpu <= resAddr;
                AErr     <= resErr;
                AHitIdx  <= resIdx;
            end
            if (AFaultClr) begin
                // A fault arriving with the clear starts a fresh capture.
                AFaultValid <= newFault;
                AFaultCnt   <= newFault ? CFaultCntW'(1) : '0;
                if (newFault) begin
                    AFaultAddr <= AAddrCpu;
                    AFaultKind <= AKind;
                end
            end else if (newFault) begin
                if (!AFaultValid) begin
                    AFaultValid <= 1'b1;
                    AFaultAddr  <= AAddrCpu;
                    AFaultKind  <= AKind;
                end
                if (AFaultCnt != '1) begin
                    AFaultCnt <= AFaultCnt + CFaultCntW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mssd_mpu_region_unit.sv
// Testbench for mssd_mpu_region_unit: directed scenarios plus random
// traffic against a behavioural model, checked through a scoreboard.
module tb_mssd_mpu_region_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        cfgWr;
    logic [3:0]  cfgIdx;
    logic [63:0] cfgMosi;
    logic [63:0] cfgMiso;
    logic        req;
    logic [1:0]  kind;
    logic [31:0] addrCpu;
    logic        ackValid;
    logic [31:0] addrMpu;
    logic        err;
    logic [3:0]  hitIdx;
    logic        faultValid;
    logic [31:0] faultAddr;
    logic [1:0]  faultKind;
    logic        faultClr;
    logic [1:0]  faultCnt;

    always #5 clk = ~clk;

    mssd_mpu_region_unit #(.CRegionCnt(4), .CFaultCntW(2)) dut (
        .AClkH(clk), .AResetH(rst), .AClkHEn(en),
        .ACfgWrEn(cfgWr), .ACfgIdx(cfgIdx), .ACfgMosi(cfgMosi),
        .ACfgMiso(cfgMiso), .AReq(req), .AKind(kind),
        .AAddrCpu(addrCpu), .AAckValid(ackValid), .AAddrMpu(addrMpu),
        .AErr(err), .AHitIdx(hitIdx), .AFaultValid(faultValid),
        .AFaultAddr(faultAddr), .AFaultKind(faultKind),
        .AFaultClr(faultClr), .AFaultCnt(faultCnt)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        err;
        logic [3:0]  idx;
        logic        fv;
        logic [31:0] fa;
        logic [1:0]  fk;
        logic [1:0]  cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    logic [63:0] mCfg [4];
    logic        mFv;
    logic [31:0] mFa;
    logic [1:0]  mFk;
    int          mCnt;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mk(input bit g, input bit x,
                                       input bit w, input bit r,
                                       input logic [19:0] nw,
                                       input logic [19:0] e,
                                       input logic [19:0] s);
        return {g, x, w, r, nw, e, s};
    endfunction

    // Reference lookup written from the region rules with plain arithmetic.
    function automatic void model(input logic [1:0] k, input logic [31:0] a,
                                  output logic [31:0] o, output logic e,
                                  output logic [3:0] idx);
        bit any = 0;
        bit found = 0;
        o = a;
        e = 0;
        idx = 0;
        for (int r = 0; r < 4; r++) begin
            logic [63:0] c = mCfg[r];
            int unsigned sh = c[63] ? 12 : 4;
            int unsigned f = (a >> sh) & 32'hFFFFF;
            int unsigned lo = 32'(c[19:0]);
            int unsigned hi = 32'(c[39:20]);
            logic [2:0] perm = c[62:60];
            if (hi != 0) begin
                any = 1;
                if (!found && f >= lo && f < hi) begin
                    found = 1;
                    idx = 4'(r);
                    o = a + (32'(c[59:40]) << sh);
                    e = (k == 2'b11) ? 1'b1 : !perm[k];
                end
            end
        end
        if (any && !found) e = 1;
    endfunction

    task automatic step(input bit r, input bit ce, input bit rq,
                        input logic [1:0] k, input logic [31:0] a,
                        input bit wr, input logic [3:0] idx,
                        input logic [63:0] mosi, input bit clr);
        logic [31:0] o;
        logic        e;
        logic [3:0]  hi;
        exp_t        x;
        @(negedge clk);
        rst = r; en = ce; req = rq; kind = k; addrCpu = a;
        cfgWr = wr; cfgIdx = idx; cfgMosi = mosi; faultClr = clr;
        #1;
        chk("miso", cfgMiso, idx < 4 ? mCfg[idx[1:0]] : 64'h0);
        if (r) begin
            for (int i = 0; i < 4; i++) mCfg[i] = '0;
            mFv = 0; mFa = 0; mFk = 0; mCnt = 0;
        end else if (ce) begin
            e = 0;
            if (rq) model(k, a, o, e, hi);
            if (clr) begin
                mFv = e;
                mCnt = e ? 1 : 0;
                if (e) begin mFa = a; mFk = k; end
            end else if (e) begin
                if (!mFv) begin mFv = 1; mFa = a; mFk = k; end
                if (mCnt < 3) mCnt++;
            end
            if (rq) begin
                x.addr = o; x.err = e; x.idx = hi; x.fv = mFv;
                x.fa = mFa; x.fk = mFk; x.cnt = 2'(mCnt);
                q.push_back(x);
            end
            if (wr && idx < 4) mCfg[idx[1:0]] = mosi;
        end
        @(posedge clk);
    endtask

    task automatic idle();
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic look(input logic [1:0] k, input logic [31:0] a);
        step(0, 1, 1, k, a, 0, 0, 0, 0);
    endtask

    task automatic wrCfg(input logic [3:0] i, input logic [63:0] c);
        step(0, 1, 0, 0, 0, 1, i, c, 0);
    endtask

    task automatic resetChk();
        #2;
        chk("rst.ack", 64'(ackValid), 0);
        chk("rst.addr", 64'(addrMpu), 0);
        chk("rst.err", 64'(err), 0);
        chk("rst.idx", 64'(hitIdx), 0);
        chk("rst.fv", 64'(faultValid), 0);
        chk("rst.fa", 64'(faultAddr), 0);
        chk("rst.fk", 64'(faultKind), 0);
        chk("rst.cnt", 64'(faultCnt), 0);
    endtask

    // Scoreboard monitor: every presented result must match the oldest
    // expectation.
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (ackValid === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpectedAck: got ack expected none at %0t",
                         $time);
            end else begin
                x = q.pop_front();
                chk("addr", 64'(addrMpu), 64'(x.addr));
                chk("err", 64'(err), 64'(x.err));
                chk("idx", 64'(hitIdx), 64'(x.idx));
                chk("fv", 64'(faultValid), 64'(x.fv));
                chk("fa", 64'(faultAddr), 64'(x.fa));
                chk("fk", 64'(faultKind), 64'(x.fk));
                chk("cnt", 64'(faultCnt), 64'(x.cnt));
            end
        end
    end

    initial begin
        logic [63:0] c;
        logic [31:0] a;
        int unsigned sh;
        int unsigned f;
        int unsigned lo;
        rst = 1; en = 1; req = 0; kind = 0; addrCpu = 0; cfgWr = 0;
        cfgIdx = 0; cfgMosi = 0; faultClr = 0;
        for (int i = 0; i < 4; i++) mCfg[i] = '0;
        mFv = 0; mFa = 0; mFk = 0; mCnt = 0;

        step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        resetChk();

        look(2'b00, 32'h1234_5678);
        #2;
        chk("t1.ack", 64'(ackValid), 1);
        chk("t1.addr", 64'(addrMpu), 64'h1234_5678);
        chk("t1.err", 64'(err), 0);

        wrCfg(0, mk(1, 0, 0, 1, 20'h00100, 20'h00020, 20'h00010));
        look(2'b00, 32'h0001_0ABC);
        #2;
        chk("t2.addr", 64'(addrMpu), 64'h0011_0ABC);
        chk("t2.idx", 64'(hitIdx), 0);
        chk("t2.err", 64'(err), 0);

        look(2'b01, 32'h0001_0000);
        #2;
        chk("t3.err", 64'(err), 1);
        chk("t3.fv", 64'(faultValid), 1);
        chk("t3.fa", 64'(faultAddr), 64'h0001_0000);
        chk("t3.fk", 64'(faultKind), 1);
        chk("t3.cnt", 64'(faultCnt), 1);

        wrCfg(1, mk(1, 0, 0, 1, 20'h00200, 20'h00016, 20'h00015));
        look(2'b00, 32'h0001_5000);
        #2;
        chk("t4.r0", 64'(addrMpu), 64'h0011_5000);
        wrCfg(0, mk(1, 0, 0, 1, 20'h00100, 20'h00000, 20'h00010));
        look(2'b00, 32'h0001_5000);
        #2;
        chk("t4.r1", 64'(addrMpu), 64'h0021_5000);
        chk("t4.idx", 64'(hitIdx), 1);

        step(0, 1, 1, 2'b00, 32'h0001_5000, 1, 1,
             mk(1, 0, 0, 1, 20'h00300, 20'h00016, 20'h00015), 0);
        #2;
        chk("t5.old", 64'(addrMpu), 64'h0021_5000);
        look(2'b00, 32'h0001_5000);
        #2;
        chk("t5.new", 64'(addrMpu), 64'h0031_5000);

        step(0, 1, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) look(2'b01, 32'h0001_5000);
        #2;
        chk("t6.sat", 64'(faultCnt), 3);
        step(0, 1, 1, 2'b11, 32'h0001_5004, 0, 0, 0, 1);
        #2;
        chk("t6.fv", 64'(faultValid), 1);
        chk("t6.cnt", 64'(faultCnt), 1);
        chk("t6.fa", 64'(faultAddr), 64'h0001_5004);
        chk("t6.fk", 64'(faultKind), 3);

        wrCfg(5, mk(1, 1, 1, 1, 20'h1, 20'h2, 20'h1));
        step(0, 1, 0, 0, 0, 0, 5, 0, 0);

        look(2'b00, 32'h0001_5000);
        step(1, 1, 1, 2'b00, 32'h0001_5000, 0, 0, 0, 0);
        resetChk();
        idle();

        for (int n = 0; n < 600; n++) begin
            int p = $urandom_range(99);
            if (p < 2) begin
                step(1, 1, $urandom_range(1), 0, $urandom, 0, 0, 0, 0);
            end else if (p < 6) begin
                idle();
                step(0, 0, 1, 2'($urandom), $urandom, $urandom_range(1),
                     4'($urandom), {$urandom, $urandom}, $urandom_range(1));
            end else if (p < 22) begin
                lo = $urandom_range(15);
                c = mk($urandom_range(1), $urandom_range(1),
                       $urandom_range(1), $urandom_range(1),
                       20'($urandom),
                       ($urandom_range(3) == 0) ? 20'h0
                                                : 20'(lo + 1 + $urandom_range(7)),
                       20'(lo));
                step(0, 1, $urandom_range(1), 2'($urandom), $urandom,
                     1, 4'($urandom_range(7)), c, 0);
            end else begin
                c = mCfg[$urandom_range(3)];
                sh = c[63] ? 12 : 4;
                f = $urandom_range(39);
                a = ($urandom & ~(32'hFFFFF << sh)) | (f << sh);
                step(0, 1, $urandom_range(3) != 0, 2'($urandom), a, 0,
                     4'($urandom_range(7)), 0, $urandom_range(19) == 0);
            end
        end
        idle();
        idle();
        chk("queueEmpty", 64'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
